// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-128 inverse round engine:
//   - AES_NR     : number of AES-128 rounds
//   - RK_IDX_W   : width of the round-key index / round counter
//   - aes_state_e: engine FSM states
//   - gf_mul, inv_shift_rows, inv_mix_columns : GF(2^8) and state helpers
// Block byte order: byte i sits in bits [127-8*i -: 8]; byte i is row i%4,
// column i/4 (column-major, as in FIPS-197).
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_NR   = 10;
    localparam int RK_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } aes_state_e;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (0x11b), shift-and-add form.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (aa & {8{b[i]}});
            aa  = {aa[6:0], 1'b0} ^ (8'h1b & {8{aa[7]}});
        end
        return acc;
    endfunction

    // Row n is rotated right by n byte positions: out[r][c] = in[r][(c-r) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    // Each column is multiplied by the circulant matrix {0e,0b,0d,09}.
    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-8*(4*c+0) -: 8];
            a1 = s[127-8*(4*c+1) -: 8];
            a2 = s[127-8*(4*c+2) -: 8];
            a3 = s[127-8*(4*c+3) -: 8];
            o[127-8*(4*c+0) -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[127-8*(4*c+1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[127-8*(4*c+2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[127-8*(4*c+3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round_engine_inv_sub_bytes.sv
// -----------------------------------------------------------------------------
// aes_inv_round_engine_inv_sub_bytes
// Purely combinational InvSubBytes over a 128-bit block (16 parallel inverse
// S-boxes).
//   data_i [127:0] : input block
//   data_o [127:0] : InvSubBytes(data_i), same byte order
// -----------------------------------------------------------------------------
module aes_inv_round_engine_inv_sub_bytes
    import aes_pkg::*;
(
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);

    // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] acc;
        p   = x;
        acc = 8'h01;
        for (int k = 0; k < 7; k++) begin
            p   = gf_mul(p, p);
            acc = gf_mul(acc, p);
        end
        return acc;
    endfunction

    // Inverse S-box: undo the affine map (rotl 1,3,6 xor 0x05), then invert.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign data_o[127-8*i -: 8] = inv_sbox(data_i[127-8*i -: 8]);
    end

endmodule

// File: rtl/aes_inv_round_engine.sv
// -----------------------------------------------------------------------------
// aes_inv_round_engine
// Iterative AES-128 inverse cipher, one round per clock, one block in flight.
// Round keys come from an external key store addressed by rk_idx and are
// returned combinationally on rk in the same cycle.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : ciphertext handshake
//   ciphertext [127:0]  : input block
//   rk_idx [3:0]        : round key index requested this cycle
//   rk [127:0]          : round key for rk_idx
//   out_valid/out_ready : plaintext handshake
//   plaintext [127:0]   : result block, driven straight from the state register
//   busy                : engine not in IDLE
// Timing: accept edge -> 9 ROUND cycles -> 1 FINAL cycle -> DONE (out_valid),
// i.e. out_valid rises 10 cycles after the accept edge.
// -----------------------------------------------------------------------------
module aes_inv_round_engine
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        ciphertext,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        plaintext,
    output logic                busy
);

    aes_state_e          fsm_q, fsm_d;
    logic [127:0]        state_q, state_d;
    logic [RK_IDX_W-1:0] r_q, r_d;

    logic [127:0]        isr_s;
    logic [127:0]        isb_s;
    logic [127:0]        ark_s;
    logic                in_ready_s;
    logic                out_valid_s;
    logic [RK_IDX_W-1:0] rk_idx_s;

    // The single InvSubBytes instance serves both ROUND and FINAL; the two
    // differ only in whether InvMixColumns follows the key addition.
    assign isr_s = inv_shift_rows(state_q);

    aes_inv_round_engine_inv_sub_bytes u_inv_sub_bytes (
        .data_i (isr_s),
        .data_o (isb_s)
    );

    assign ark_s = isb_s ^ rk;

    // FSM, block state and round counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            r_q     <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            r_q     <= r_d;
        end
    end

    // Next-state, datapath select, key index and handshake decode
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        r_d         = r_q;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        rk_idx_s    = '0;
        case (fsm_q)
            ST_IDLE: begin
                // Reset must mask in_ready in the same cycle it is asserted.
                in_ready_s = ~rst;
                rk_idx_s   = RK_IDX_W'(NR);
                if (in_valid && in_ready_s) begin
                    state_d = ciphertext ^ rk;
                    r_d     = RK_IDX_W'(NR - 1);
                    fsm_d   = ST_ROUND;
                end else begin
                    fsm_d   = ST_IDLE;
                end
            end
            ST_ROUND: begin
                rk_idx_s = r_q;
                state_d  = inv_mix_columns(ark_s);
                r_d      = r_q - 4'd1;
                if (r_q == 4'd1) begin
                    fsm_d = ST_FINAL;
                end else begin
                    fsm_d = ST_ROUND;
                end
            end
            ST_FINAL: begin
                rk_idx_s = 4'd0;
                state_d  = ark_s;
                fsm_d    = ST_DONE;
            end
            ST_DONE: begin
                rk_idx_s    = 4'd0;
                out_valid_s = 1'b1;
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end else begin
                    fsm_d = ST_DONE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign rk_idx    = rk_idx_s;
    assign plaintext = state_q;
    assign busy      = (fsm_q != ST_IDLE);

endmodule

// File: doc/aes_inv_round_engine.md
AES_INV_ROUND_ENGINE -- requirements
Module: aes_inv_round_engine

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES-128 rounds; only the value 10 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, ciphertext offered.
REQ-005 SHALL have port in_ready, output, 1, engine can accept a ciphertext.
REQ-006 SHALL have port ciphertext, input, 128, input block; byte 0 = bits[127:120], column-major per FIPS-197.
REQ-007 SHALL have port rk_idx, output, 4, index of the round key required this cycle.
REQ-008 SHALL have port rk, input, 128, round key rk_idx, supplied combinationally by an external key store in the same cycle.
REQ-009 SHALL have port out_valid, output, 1, plaintext available.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts plaintext.
REQ-011 SHALL have port plaintext, output, 128, result block, same byte order as ciphertext.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, ROUND, FINAL and DONE, with one 128-bit state register and a 4-bit round counter r.
REQ-014 In IDLE, in_ready SHALL be 1 and rk_idx SHALL be NR; on in_valid&in_ready the engine SHALL load state = ciphertext ^ rk, set r = NR-1, and enter ROUND.
REQ-015 In ROUND, rk_idx SHALL be r; each cycle state SHALL become InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk) and r SHALL decrement; when r==1 the next state SHALL be FINAL.
REQ-016 In FINAL, rk_idx SHALL be 0; the engine SHALL compute state = InvSubBytes(InvShiftRows(state)) ^ rk and enter DONE.
REQ-017 In DONE, out_valid SHALL be 1 and plaintext SHALL equal the state register, held stable until out_ready; on out_valid&out_ready the engine SHALL return to IDLE.
REQ-018 Latency SHALL be exactly 10 cycles from the accept edge to out_valid high, with one block in flight at a time.
REQ-019 in_ready SHALL be 0 in ROUND, FINAL and DONE; in_valid in those states SHALL be ignored and the ciphertext SHALL NOT be latched.
REQ-020 The DONE->IDLE transition SHALL take one cycle, so a new block can be accepted no earlier than the cycle after the output handshake; throughput is 1 block per 12 cycles with no back-pressure.
REQ-021 InvShiftRows SHALL rotate row n right by n bytes (n=0..3); InvMixColumns SHALL use the GF(2^8) coefficients {0e,0b,0d,09} with polynomial 0x11b.
REQ-022 plaintext SHALL be driven from the state register only, with no combinational path from ciphertext or rk.
REQ-023 rk_idx SHALL be a pure function of FSM state and r: IDLE=10, ROUND=r, FINAL=0, DONE=0.

Reset
REQ-024 While rst is high at a clock edge the engine SHALL enter IDLE with r=0, state register=0, out_valid=0 and busy=0.
REQ-025 in_ready SHALL be 0 in any cycle where rst is high, and 1 from the first cycle after rst is deasserted.
REQ-026 A reset asserted in ROUND, FINAL or DONE SHALL abandon the block, and no out_valid for that block SHALL ever appear.

Structure
REQ-027 The shared package aes_pkg SHALL hold NR, the FSM state enum, the round-index width, and the GF multiply/InvMixColumns/InvShiftRows functions.
REQ-028 The engine SHALL instantiate exactly one existing InvSubBytes sub-module, shared between ROUND and FINAL; no other sub-module is required.

Verification
REQ-029 FIPS-197 App. C.1: key 000102..0f (round keys from the reference model), ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, out_valid 10 cycles after accept.
REQ-030 The rk_idx sequence after accept SHALL be checked: 10 on the accept cycle, then 9,8,...,1, then 0.
REQ-031 Back-pressure: hold out_ready=0 for 5 cycles in DONE -> plaintext and out_valid are stable, in_ready=0, and a pending in_valid is not accepted.
REQ-032 Back-to-back: two ciphertexts with in_valid held and out_ready=1 -> the second is accepted exactly 2 cycles after the first out_valid, and both results are correct.
REQ-033 Reset mid-operation: assert rst at round r=5 -> out_valid=0 and in_ready=1 the cycle after release, and a fresh App. C.1 block decrypts correctly.
REQ-034 Random: 1000 random key/ciphertext pairs with random in_valid/out_ready stalls -> all outputs match the software AES-128 inverse cipher.
